// File: rtl/ptw_arbiter.sv
// ptw_arbiter: shares one page-table walker between the I-side and D-side
// TLB miss paths. Round-robin on conflicting misses, merges misses to the
// same virtual page into one walk, and fans the walker's PTE line back out.
//
// Handshakes: a requester holds req_valid until it sees a one-cycle
// req_ready; dropping req_valid before that withdraws the request. A
// response is offered with resp_valid (level) until the matching resp_ack,
// which may arrive in the very cycle resp_valid rises. walk_enable is a
// single-cycle start pulse; walk_ready is a level qualifying walk_ptes.
module ptw_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int VPN_HI         = 47,
    parameter int VPN_LO         = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BUS_DATA_WIDTH-1:0]     ptbr,
    input  logic                          i_req_valid,
    input  logic [BUS_DATA_WIDTH-1:0]     i_req_vaddr,
    output logic                          i_req_ready,
    output logic                          i_resp_valid,
    input  logic                          i_resp_ack,
    input  logic                          d_req_valid,
    input  logic [BUS_DATA_WIDTH-1:0]     d_req_vaddr,
    output logic                          d_req_ready,
    output logic                          d_resp_valid,
    input  logic                          d_resp_ack,
    output logic [BUS_DATA_WIDTH*8-1:0]   resp_ptes,
    output logic                          walk_enable,
    output logic [BUS_DATA_WIDTH-1:0]     walk_virt_addr,
    output logic [BUS_DATA_WIDTH-1:0]     walk_ptbr,
    input  logic                          walk_ready,
    input  logic [BUS_DATA_WIDTH*8-1:0]   walk_ptes,
    output logic [1:0]                    dbg_state
);

    localparam int VPN_W = VPN_HI - VPN_LO + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_DELIVER = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic [1:0]                  mask_q, mask_d;        // bit0 = I-side, bit1 = D-side
    logic                        last_grant_q, last_grant_d; // 0 = I, 1 = D
    logic [BUS_DATA_WIDTH-1:0]   vaddr_q, vaddr_d;
    logic [BUS_DATA_WIDTH-1:0]   ptbr_q, ptbr_d;
    logic [BUS_DATA_WIDTH*8-1:0] pte_buf_q, pte_buf_d;
    logic                        first_wait_q, first_wait_d; // walker ready is stale here

    logic [VPN_W-1:0] i_vpn, d_vpn, q_vpn;
    logic             i_acc, d_acc;

    assign i_vpn = i_req_vaddr[VPN_HI:VPN_LO];
    assign d_vpn = d_req_vaddr[VPN_HI:VPN_LO];
    assign q_vpn = vaddr_q[VPN_HI:VPN_LO];

    // Next-state: arbitration/accept in IDLE, merge during the walk, ack drain in DELIVER.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        last_grant_d = last_grant_q;
        vaddr_d      = vaddr_q;
        ptbr_d       = ptbr_q;
        pte_buf_d    = pte_buf_q;
        first_wait_d = first_wait_q;
        i_acc        = 1'b0;
        d_acc        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid && d_req_valid) begin
                    if (i_vpn == d_vpn) begin
                        // Same page: one walk serves both, no grant change.
                        i_acc = 1'b1;
                        d_acc = 1'b1;
                    end else if (last_grant_q) begin
                        i_acc        = 1'b1;
                        last_grant_d = 1'b0;
                    end else begin
                        d_acc        = 1'b1;
                        last_grant_d = 1'b1;
                    end
                end else if (i_req_valid) begin
                    i_acc        = 1'b1;
                    last_grant_d = 1'b0;
                end else if (d_req_valid) begin
                    d_acc        = 1'b1;
                    last_grant_d = 1'b1;
                end
                if (i_acc || d_acc) begin
                    vaddr_d = i_acc ? i_req_vaddr : d_req_vaddr;
                    ptbr_d  = ptbr;
                    mask_d  = {d_acc, i_acc};
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT: begin
                // A late miss to the page already being walked rides along.
                i_acc  = !mask_q[0] && i_req_valid && (i_vpn == q_vpn);
                d_acc  = !mask_q[1] && d_req_valid && (d_vpn == q_vpn);
                mask_d = mask_q | {d_acc, i_acc};
                if (state_q == S_ISSUE) begin
                    state_d      = S_WAIT;
                    first_wait_d = 1'b1;
                end else begin
                    first_wait_d = 1'b0;
                    if (!first_wait_q && walk_ready) begin
                        pte_buf_d = walk_ptes;
                        state_d   = S_DELIVER;
                    end
                end
            end
            S_DELIVER: begin
                mask_d = mask_q & ~{d_resp_ack, i_resp_ack};
                if (mask_d == 2'b00) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mask_q       <= 2'b00;
            last_grant_q <= 1'b1;
            vaddr_q      <= '0;
            ptbr_q       <= '0;
            pte_buf_q    <= '0;
            first_wait_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            last_grant_q <= last_grant_d;
            vaddr_q      <= vaddr_d;
            ptbr_q       <= ptbr_d;
            pte_buf_q    <= pte_buf_d;
            first_wait_q <= first_wait_d;
        end
    end

    assign i_req_ready    = i_acc & ~reset;
    assign d_req_ready    = d_acc & ~reset;
    assign walk_enable    = (state_q == S_ISSUE);
    assign i_resp_valid   = (state_q == S_DELIVER) & mask_q[0];
    assign d_resp_valid   = (state_q == S_DELIVER) & mask_q[1];
    assign resp_ptes      = pte_buf_q;
    assign walk_virt_addr = vaddr_q;
    assign walk_ptbr      = ptbr_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Testbench for ptw_arbiter: vector table for the IDLE arbitration rules,
// directed multi-cycle sequences, and a randomized run scored against a
// transaction-level model of the accept/merge/deliver rules.
module tb_ptw_arbiter;

    localparam int W  = 64;
    localparam int LW = W * 8;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DELIVER = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic [W-1:0]  ptbr = '0;
    logic          i_req_valid = 1'b0, d_req_valid = 1'b0;
    logic [W-1:0]  i_req_vaddr = '0, d_req_vaddr = '0;
    logic          i_req_ready, d_req_ready, i_resp_valid, d_resp_valid;
    logic          i_resp_ack = 1'b0, d_resp_ack = 1'b0;
    logic [LW-1:0] resp_ptes;
    logic          walk_enable;
    logic [W-1:0]  walk_virt_addr, walk_ptbr;
    logic          walk_ready = 1'b0;
    logic [LW-1:0] walk_ptes = '0;
    logic [1:0]    dbg_state;

    ptw_arbiter #(.BUS_DATA_WIDTH(W), .VPN_HI(47), .VPN_LO(12)) dut (
        .clk(clk), .reset(reset), .ptbr(ptbr),
        .i_req_valid(i_req_valid), .i_req_vaddr(i_req_vaddr), .i_req_ready(i_req_ready),
        .i_resp_valid(i_resp_valid), .i_resp_ack(i_resp_ack),
        .d_req_valid(d_req_valid), .d_req_vaddr(d_req_vaddr), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_ack(d_resp_ack),
        .resp_ptes(resp_ptes), .walk_enable(walk_enable),
        .walk_virt_addr(walk_virt_addr), .walk_ptbr(walk_ptbr),
        .walk_ready(walk_ready), .walk_ptes(walk_ptes), .dbg_state(dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int chk_cnt = 0, pass_cnt = 0, cyc = 0, s_cyc = 0;

    logic          s_rdy[2], s_rv[2], s_en;
    logic [LW-1:0] s_ptes;
    logic [W-1:0]  s_wva, s_wptbr;
    logic [1:0]    s_dbg;

    logic         val_in[2] = '{1'b0, 1'b0};
    logic [W-1:0] va_in[2]  = '{64'h0, 64'h0};
    logic         ack_in[2] = '{1'b0, 1'b0};

    // walker model: raises ready wk_delay cycles after enable with a fresh
    // line; an old ready level lingers through the enable and next cycle
    bit            wk_busy = 0, wk_rand = 0;
    int            wk_k = 0, wk_delay = 2, wk_rise_cyc = -1, en_cyc = -1, en_cnt = 0;
    logic [LW-1:0] wk_fresh = '0;

    // randomized-run scoreboard
    bit           rnd_on = 0, rnd_stop = 0;
    bit           pend[2], acc[2], resp_seen;
    int           age[2], max_age, acc_cnt, done_cnt;
    logic [35:0]  walk_vpn;
    logic [W-1:0] exp_ptbr;
    logic [W-1:0] exp_q[$];
    logic [35:0]  pool[4] = '{36'h1, 36'h2, 36'h3, 36'h8_0000_0001};

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [35:0] vpn(input logic [W-1:0] a);
        return a[47:12];
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int j = 0; j < LW / 32; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- model ----------------
    task automatic model_step();
        bit busy_before;
        bit acc_pre[2];
        int prim;
        busy_before = acc[0] | acc[1];
        acc_pre = acc;
        for (int s = 0; s < 2; s++) begin
            if (pend[s] && !s_rdy[s]) begin
                age[s]++;
                if (age[s] > max_age) max_age = age[s];
            end else age[s] = 0;
            if (s_rv[s]) begin
                check("resp_owner", acc[s], 1);
                check("resp_ptes", s_ptes, wk_fresh);
                resp_seen = 1;
                if (ack_in[s]) begin
                    acc[s] = 0;
                    done_cnt++;
                end
            end
        end
        if (s_rdy[0] || s_rdy[1]) begin
            for (int s = 0; s < 2; s++) if (s_rdy[s]) begin
                check("rdy_has_valid", val_in[s], 1);
                check("rdy_side_free", acc_pre[s], 0);
                if (busy_before) begin
                    check("merge_vpn", vpn(va_in[s]), walk_vpn);
                    check("merge_before_deliver", resp_seen, 0);
                end
            end
            if (!busy_before) begin
                prim = s_rdy[0] ? 0 : 1;
                if (s_rdy[0] && s_rdy[1]) check("idle_merge_vpn", vpn(va_in[1]), vpn(va_in[0]));
                walk_vpn  = vpn(va_in[prim]);
                exp_q.push_back(va_in[prim]);
                exp_ptbr  = ptbr;
                resp_seen = 0;
            end
            for (int s = 0; s < 2; s++) if (s_rdy[s]) begin
                acc[s]  = 1;
                pend[s] = 0;
                acc_cnt++;
            end
        end
        if (s_en) begin
            check("enable_has_walk", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("walk_vaddr", s_wva, exp_q.pop_front());
            check("walk_ptbr", s_wptbr, exp_ptbr);
        end
    endtask

    // ---------------- driver ----------------
    // one clock cycle: apply inputs, sample outputs 1ns later, advance
    task automatic tick();
        i_req_valid = val_in[0]; i_req_vaddr = va_in[0]; i_resp_ack = ack_in[0];
        d_req_valid = val_in[1]; d_req_vaddr = va_in[1]; d_resp_ack = ack_in[1];
        if (wk_busy) begin
            wk_k++;
            if (wk_k >= wk_delay) begin
                wk_fresh    = rand_line();
                walk_ptes   = wk_fresh;
                walk_ready  = 1'b1;
                wk_busy     = 0;
                wk_rise_cyc = cyc;
            end else if (wk_k >= 2) walk_ready = 1'b0;
        end
        #1;
        s_rdy[0] = i_req_ready;  s_rdy[1] = d_req_ready;
        s_rv[0]  = i_resp_valid; s_rv[1]  = d_resp_valid;
        s_en = walk_enable; s_ptes = resp_ptes; s_wva = walk_virt_addr;
        s_wptbr = walk_ptbr; s_dbg = dbg_state; s_cyc = cyc;
        if (s_en) begin
            wk_busy = 1; wk_k = 0; en_cyc = cyc; en_cnt++;
            if (wk_rand) wk_delay = $urandom_range(2, 8);
        end
        if (rnd_on) model_step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input bit keep_walker);
        val_in = '{1'b0, 1'b0};
        ack_in = '{1'b0, 1'b0};
        reset = 1'b1;
        if (!keep_walker) begin
            wk_busy = 0;
            walk_ready = 1'b0;
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        ack_in = '{1'b1, 1'b1};
        for (int n = 0; n < 60; n++) begin
            tick();
            if (s_dbg == ST_IDLE && !s_rv[0] && !s_rv[1]) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    task automatic drive_random();
        for (int s = 0; s < 2; s++) begin
            if (pend[s]) begin
                if (!rnd_stop && $urandom_range(0, 15) == 0) pend[s] = 0;
            end else if (!acc[s] && !rnd_stop && $urandom_range(0, 2) == 0) begin
                pend[s] = 1;
                va_in[s] = {16'($urandom), pool[$urandom_range(0, 3)], 12'($urandom)};
            end
            val_in[s] = pend[s];
            ack_in[s] = 1'($urandom_range(0, 1));
        end
        ptbr = {$urandom, $urandom};
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string        name;
        logic         iv, dv;
        logic [W-1:0] iva, dva;
        logic         exp_ir, exp_dr;
        logic [W-1:0] exp_va;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i_ack_c, d_c, en0, bad, rcyc;
        bit found;
        logic [LW-1:0] old_line;

        vecs[0] = '{"only_i",   1, 0, 64'h0000_1234_5000, 64'h0,              1, 0, 64'h0000_1234_5000};
        vecs[1] = '{"only_d",   0, 1, 64'h0,              64'h0000_0abc_d008, 0, 1, 64'h0000_0abc_d008};
        vecs[2] = '{"same_vpn", 1, 1, 64'h7000,           64'h7ff8,           1, 1, 64'h7000};
        vecs[3] = '{"diff_vpn", 1, 1, 64'h1000,           64'h2000,           1, 0, 64'h1000};
        vecs[4] = '{"bit47",    1, 1, 64'h0000_8000_0000_3000, 64'h3000,      1, 0, 64'h0000_8000_0000_3000};
        vecs[5] = '{"above_hi", 1, 1, 64'h0001_0000_0000_4000, 64'h4000,      1, 1, 64'h0001_0000_0000_4000};
        vecs[6] = '{"bit11",    1, 1, 64'h5800,           64'h5000,           1, 1, 64'h5800};
        vecs[7] = '{"bit12",    1, 1, 64'h6000,           64'h7000,           1, 0, 64'h6000};
        vecs[8] = '{"none",     0, 0, 64'h6000,           64'h7000,           0, 0, 64'h0};

        @(negedge clk);

        // reset state
        do_reset(0);
        tick();
        check("rst_ctrl", {s_rdy[0], s_rdy[1], s_rv[0], s_rv[1], s_en, s_dbg}, 7'b0);
        check("rst_wva", s_wva, 0);
        check("rst_wptbr", s_wptbr, 0);
        check("rst_ptes", s_ptes, 0);

        // IDLE arbitration table, each from reset (I wins the first tie)
        for (int v = 0; v < 9; v++) begin
            do_reset(0);
            ptbr = 64'h8000_0000 + 64'(v) * 64'h1000;
            val_in = '{vecs[v].iv, vecs[v].dv};
            va_in  = '{vecs[v].iva, vecs[v].dva};
            tick();
            check({vecs[v].name, "_ready"}, {s_rdy[0], s_rdy[1]}, {vecs[v].exp_ir, vecs[v].exp_dr});
            val_in = '{1'b0, 1'b0};
            tick();
            check({vecs[v].name, "_enable"}, s_en, vecs[v].exp_ir | vecs[v].exp_dr);
            check({vecs[v].name, "_wva"}, s_wva, vecs[v].exp_va);
            check({vecs[v].name, "_wptbr"}, s_wptbr,
                  (vecs[v].exp_ir | vecs[v].exp_dr) ? 64'h8000_0000 + 64'(v) * 64'h1000 : 64'h0);
        end

        // single I miss, walker 20 cycles
        do_reset(0);
        wk_delay = 20;
        ptbr = 64'h8000_0000;
        val_in[0] = 1; va_in[0] = 64'h0000_1234_5000;
        tick();
        check("s1_accept", {s_rdy[0], s_rdy[1]}, 2'b10);
        rcyc = s_cyc;
        val_in[0] = 0;
        tick();
        check("s1_enable", s_en, 1);
        check("s1_wva", s_wva, 64'h0000_1234_5000);
        check("s1_wptbr", s_wptbr, 64'h8000_0000);
        bad = 0; found = 0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (s_rv[1] || s_rdy[1] || s_rdy[0] || s_en) bad++;
            if (s_rv[0]) begin found = 1; break; end
        end
        check("s1_resp_seen", found, 1);
        check("s1_resp_after_ready", s_cyc, wk_rise_cyc + 1);
        check("s1_latency", s_cyc, rcyc + 22);
        check("s1_ptes", s_ptes, wk_fresh);
        check("s1_quiet", bad, 0);
        ack_in[0] = 1;
        tick();
        check("s1_hold_until_ack", s_rv[0], 1);
        ack_in[0] = 0;
        tick();
        check("s1_after_ack", {s_rv[0], s_dbg}, {1'b0, ST_IDLE});

        // tie with different VPNs: I first, D the cycle after I's ack
        do_reset(0);
        wk_delay = 3;
        va_in = '{64'h1000, 64'h2000};
        val_in = '{1'b1, 1'b1};
        ack_in = '{1'b1, 1'b1};
        tick();
        check("tie1_grant_i", {s_rdy[0], s_rdy[1]}, 2'b10);
        val_in[0] = 0; i_ack_c = -100; d_c = -1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (s_rv[0]) i_ack_c = s_cyc;
            if (s_rdy[1]) begin d_c = s_cyc; break; end
        end
        check("tie1_loser_after_ack", d_c, i_ack_c + 1);
        val_in[1] = 0;
        wait_idle("tie1_idle");
        val_in = '{1'b1, 1'b1};
        tick();
        check("tie2_grant_i_after_d", {s_rdy[0], s_rdy[1]}, 2'b10);

        // I served last, then a tie goes to D
        do_reset(0);
        val_in[0] = 1; va_in[0] = 64'h1000;
        tick();
        val_in[0] = 0;
        wait_idle("ilast_idle");
        va_in = '{64'h1000, 64'h2000};
        val_in = '{1'b1, 1'b1};
        tick();
        check("tie3_grant_d", {s_rdy[0], s_rdy[1]}, 2'b01);

        // same VPN: one walk, both responses, acks on different cycles
        do_reset(0);
        wk_delay = 4;
        va_in = '{64'h7000, 64'h7ff8};
        val_in = '{1'b1, 1'b1};
        tick();
        check("same_both_ready", {s_rdy[0], s_rdy[1]}, 2'b11);
        val_in = '{1'b0, 1'b0};
        en0 = en_cnt; found = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (s_rv[0] && s_rv[1]) begin found = 1; break; end
        end
        check("same_both_resp", found, 1);
        check("same_one_walk", en_cnt - en0, 1);
        check("same_ptes", s_ptes, wk_fresh);
        ack_in[0] = 1;
        tick();
        ack_in[0] = 0;
        tick();
        check("same_after_i_ack", {s_rv[0], s_rv[1], s_dbg}, {2'b01, ST_DELIVER});
        ack_in[1] = 1;
        tick();
        ack_in[1] = 0;
        tick();
        check("same_after_d_ack", {s_rv[0], s_rv[1], s_dbg}, {2'b00, ST_IDLE});

        // matching D miss during WAIT merges into the walk
        do_reset(0);
        wk_delay = 6;
        val_in[0] = 1; va_in[0] = 64'h5000;
        tick();
        val_in[0] = 0;
        tick();
        en0 = en_cnt;
        val_in[1] = 1; va_in[1] = 64'h5abc;
        tick();
        check("wait_merge_ready", s_rdy[1], 1);
        val_in[1] = 0;
        ack_in = '{1'b1, 1'b1};
        found = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (s_rv[0] && s_rv[1]) begin found = 1; break; end
        end
        check("wait_merge_both_resp", found, 1);
        check("wait_merge_no_second_walk", en_cnt, en0);
        tick();
        check("wait_merge_idle", s_dbg, ST_IDLE);

        // non-matching D miss during WAIT waits until after DELIVER
        do_reset(0);
        wk_delay = 5;
        val_in[0] = 1; va_in[0] = 64'h5000;
        tick();
        val_in[0] = 0;
        tick();
        val_in[1] = 1; va_in[1] = 64'h9000;
        ack_in = '{1'b1, 1'b1};
        i_ack_c = -100; d_c = -1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (s_rv[0]) i_ack_c = s_cyc;
            if (s_rdy[1]) begin d_c = s_cyc; break; end
        end
        check("wait_nomatch_after_deliver", d_c, i_ack_c + 1);
        val_in[1] = 0;
        wait_idle("wait_nomatch_idle");

        // stale walk_ready through ISSUE and the first WAIT cycle
        do_reset(0);
        old_line = rand_line();
        walk_ptes = old_line;
        wk_fresh = old_line;
        walk_ready = 1'b1;
        wk_delay = 7;
        val_in[0] = 1; va_in[0] = 64'ha000;
        ack_in = '{1'b1, 1'b1};
        tick();
        val_in[0] = 0;
        found = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (s_rv[0]) begin found = 1; break; end
        end
        check("stale_resp_seen", found, 1);
        check("stale_resp_cycle", s_cyc, en_cyc + 8);
        check("stale_fresh_ptes", s_ptes, wk_fresh);
        wait_idle("stale_idle");

        // reset in WAIT drops the walk; later walker ready is ignored
        do_reset(0);
        wk_delay = 6;
        val_in[0] = 1; va_in[0] = 64'hb000;
        ptbr = 64'h1234_0000;
        tick();
        val_in[0] = 0;
        tick();
        tick();
        tick();
        do_reset(1);
        tick();
        check("midrst_ctrl", {s_rdy[0], s_rdy[1], s_rv[0], s_rv[1], s_en, s_dbg}, 7'b0);
        check("midrst_wva", s_wva, 0);
        check("midrst_wptbr", s_wptbr, 0);
        ack_in = '{1'b1, 1'b1};
        bad = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (s_rv[0] || s_rv[1] || s_en) bad++;
        end
        check("midrst_no_resp", bad, 0);

        // randomized run against the transaction model
        do_reset(0);
        wk_rand = 1;
        pend = '{0, 0}; acc = '{0, 0}; age = '{0, 0};
        max_age = 0; acc_cnt = 0; done_cnt = 0; resp_seen = 0;
        rnd_on = 1;
        for (int n = 0; n < 3000; n++) begin
            drive_random();
            tick();
        end
        rnd_stop = 1;
        found = 0;
        for (int n = 0; n < 400; n++) begin
            if (!(pend[0] | pend[1] | acc[0] | acc[1])) begin found = 1; break; end
            drive_random();
            tick();
        end
        rnd_on = 0;
        check("rnd_drained", found, 1);
        check("rnd_all_delivered", done_cnt, acc_cnt);
        check("rnd_exp_q_empty", exp_q.size(), 0);
        check("rnd_no_starvation", max_age <= 100, 1);
        check("rnd_activity", acc_cnt > 100, 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ptw_arbiter.md
# ptw_arbiter

Shares the single page-table walker (`va_to_pa`-style Sv48 walker) between the instruction-side and data-side TLB miss paths. It accepts one miss per requester and arbitrates round-robin when both miss together. It merges misses to the same virtual page into one walk, sequences the walker's enable/ready handshake, and returns the walker's 8-PTE line to every requester it served. It sits between the two TLBs and the walker, which owns its bus/arbiter port.

## Interface
- BUS_DATA_WIDTH, 64, width of vaddr, ptbr and each PTE
- VPN_HI, 47, top bit of the virtual page number compared for merging
- VPN_LO, 12, bottom bit of the virtual page number compared for merging

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ptbr  in  BUS_DATA_WIDTH  page-table base; sampled at accept
- i_req_valid  in  1  I-side miss request; held until i_req_ready
- i_req_vaddr  in  BUS_DATA_WIDTH  I-side miss address
- i_req_ready  out  1  one-cycle accept pulse
- i_resp_valid  out  1  PTE line valid for I-side
- i_resp_ack  in  1  I-side consumes response
- d_req_valid / d_req_vaddr / d_req_ready / d_resp_valid / d_resp_ack  same widths and meaning, D-side
- resp_ptes  out  BUS_DATA_WIDTH*8  registered PTE line shared by both responses
- walk_enable  out  1  one-cycle start pulse to walker
- walk_virt_addr  out  BUS_DATA_WIDTH  registered vaddr, stable from ISSUE until DELIVER
- walk_ptbr  out  BUS_DATA_WIDTH  registered ptbr, same stability
- walk_ready  in  1  walker done (level)
- walk_ptes  in  BUS_DATA_WIDTH*8  walker PTE line, valid while walk_ready

## Operation
- State machine: IDLE, ISSUE, WAIT, DELIVER.
- Registers:
  - serve_mask[1:0]: bit0 = I-side, bit1 = D-side.
  - last_grant: 0 = I-side, 1 = D-side.
  - vaddr_q, ptbr_q, pte_buf.
- IDLE, one valid requester: accept it. Pulse its req_ready, latch vaddr_q/ptbr_q, set its mask bit, go to ISSUE.
- IDLE, both valid, vaddr[VPN_HI:VPN_LO] equal: accept both in the same cycle (both ready pulses). Mask = 2'b11. Latch the I-side vaddr.
- IDLE, both valid, VPNs differ: grant the side ≠ last_grant. Update last_grant to the granted side. The loser stays pending and is not acknowledged.
- Single-requester accept also sets last_grant to that side.
- ISSUE: walk_enable=1 for exactly this cycle. Go to WAIT.
- ISSUE/WAIT merge: if the unserved side raises req_valid with VPN equal to vaddr_q's VPN, accept it that cycle. Pulse its ready and set its mask bit. A non-matching request waits.
- WAIT: walk_ready is ignored in the first WAIT cycle, because the walker's ready is still stale from the previous walk. From the second WAIT cycle on, walk_ready=1 latches walk_ptes into pte_buf and moves to DELIVER.
- DELIVER:
  - resp_valid = mask bit for each side; resp_ptes = pte_buf.
  - An ack clears that side's mask bit; resp_valid drops the next cycle.
  - When mask == 0, go to IDLE.
  - No merges or accepts happen in DELIVER.
- An ack while that side's resp_valid=0 has no effect.

## Timing
- Reset state: IDLE, mask=0, last_grant=1 (I-side wins the first tie), pte_buf=0, vaddr_q=ptbr_q=0.
- Reset values of outputs: all ready/valid/enable outputs 0, walk_virt_addr=0, walk_ptbr=0, resp_ptes=0.
- Accept in cycle T (IDLE) → walk_enable in T+1 → WAIT from T+2. walk_ready is sampled from T+3 on.
- walk_ready first seen at cycle W → resp_valid from W+1.
- Ack in the same cycle resp_valid rises is legal. The earliest next accept is the cycle after the last ack.
- Minimum miss-to-response latency is 4 cycles, plus the walker time.
- Reset mid-walk: the arbiter returns to IDLE, dropping the in-flight walk and any served state. The walker shares this reset. Requesters must re-request.
- A request deasserted before ready is treated as withdrawn; the arbiter never latches it.
- Both acks arriving in the same cycle: mask→0, IDLE next cycle.

## Test plan
- Single I miss, vaddr=0x0000_1234_5000, ptbr=0x8000_0000, walker ready 20 cycles after enable: one i_req_ready pulse; walk_enable 1 cycle later; i_resp_valid 1 cycle after walk_ready with resp_ptes equal to walker data; d_* stay 0.
- Both valid after reset with different VPNs (0x1000, 0x2000): I-side is served first. D is accepted in the IDLE cycle after I's ack. Then a repeated tie grants I again only after D was last.
- Both valid with the same VPN (0x7000 vs 0x7ff8): a single walk_enable; both ready pulses in the same cycle; both resp_valid with identical resp_ptes; acks on different cycles; IDLE only after the second ack.
- D raises a matching VPN during WAIT: accepted that cycle; no second walk_enable; both responses delivered. A non-matching VPN during WAIT is not accepted until after DELIVER.
- Stale ready: walk_ready held 1 through ISSUE and the first WAIT cycle, then 0 for 5 cycles, then 1: DELIVER only after the final rise.
- Reset asserted in WAIT: the next cycle shows IDLE; all outputs 0; no resp_valid follows the walker's later ready.
